regdst_wb_sched: RTL
====================

# regdst_wb_sched

Write-back scheduler for the register-file write port. It arbitrates up to `N_REQ` write-back requesters and drives the 3-bit destination-select code into the RegDst multiplexer, along with the write data and `reg_write`. It also sequences paired (two-register) writes over consecutive cycles. It sits between the multicycle control unit's write-back sources and the register bank.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: write-data width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input N_REQ: per-requester write request; held until its `grant` pulse.
- `pair` input N_REQ: the request performs two writes.
- `dst_code` input 3*N_REQ: first-write RegDst code, slice i for requester i.
- `dst2_code` input 3*N_REQ: second-write code; used only when `pair[i]`=1.
- `wdata` input DATA_W*N_REQ: first-write data.
- `wdata2` input DATA_W*N_REQ: second-write data.
- `stall` input 1: freezes the scheduler.
- `grant` output N_REQ: one-hot completion pulse.
- `RegDst_control` output 3: destination-select code to the RegDst mux.
- `reg_write` output 1: register-file write enable.
- `wb_data` output DATA_W: write data.
- `busy` output 1: FSM not in IDLE.
- `bad_code` output 1: pulse when the current write carries an illegal code.

## Operation
- Legal RegDst codes: 000 rt, 001 rd, 010 $ra (31), 011 $sp (29), 100 rs. Codes 101–111 are illegal.
- FSM states: IDLE, WR1, WR2.
- IDLE, with `stall`=0 and any `req`:
  - Select the winner, latch its codes, data and `pair` bit, and go to WR1.
  - If there is no request or `stall`=1, stay in IDLE.
- WR1 presents the first write.
  - If the latched `pair`=1, go to WR2.
  - Otherwise pulse `grant[winner]` and go to IDLE.
- WR2 presents the second write, pulses `grant[winner]` and goes to IDLE.
- `RegDst_control`, `wb_data`, `busy` and the state are registered.
- `reg_write` = (state is WR1 or WR2) AND NOT `stall` AND code legal.
- `grant` is the completion pulse, gated by NOT `stall`.
- `bad_code` = (state is WR1 or WR2) AND NOT `stall` AND code illegal.
- An illegal-code write is suppressed: no `reg_write`, `bad_code`=1. The sequence otherwise proceeds normally, including the `grant`.
- `stall`=1 in WR1 or WR2 holds the state and the registered outputs. `reg_write`, `grant` and `bad_code` are 0 during the stall. The write is presented again when `stall` falls.
- Winner inputs are latched in IDLE. Requester input changes after that point have no effect on the write in progress.

## Timing
- Reset values: state IDLE, `grant`=0, `RegDst_control`=000, `reg_write`=0, `wb_data`=0, `busy`=0, `bad_code`=0, round-robin pointer=0.
- Request seen in IDLE at cycle k → first write visible at cycle k+1.
- Single write: `grant` in cycle k+1.
- Paired write: second write and `grant` in cycle k+2.
- Requesters drop or replace `req` at the edge following their `grant`.
- Re-arbitration happens only in IDLE. Peak throughput is one single write per 2 cycles, or one paired write per 3 cycles.
- A `req` that rises during WR1/WR2 waits for IDLE. No request is lost or granted twice.
- `reset` mid-sequence: the next cycle is IDLE with all outputs at reset values. No `grant` is issued and the latched request is discarded. Because the requester still holds `req`, it is re-arbitrated.
- Simultaneous `stall` fall and `reset`: reset wins.

## Configuration
- `REGDST_WB_RR_FAIR_EN` defined: round-robin arbitration.
  - The winner is the first requesting index at or after the pointer, modulo N_REQ.
  - On `grant`, the pointer becomes winner+1, modulo N_REQ.
  - The pointer is unchanged on stall and on reset-discard.
- Undefined: fixed priority, lowest index wins, and the pointer logic is absent.

## Test plan
- Reset, then `req`=0001, code 001, `wdata`=0x0000_00AA → cycle+1: `reg_write`=1, `RegDst_control`=001, `wb_data`=0xAA, `grant`=0001. `busy` is 0 one cycle later.
- Paired: `req`=0100, codes 011 then 010, data 0x1000 then 0x2000 → two consecutive writes with those codes and data. `grant`=0100 only on the second write.
- `req`=1111 held, each requester dropping `req` after its own `grant`:
  - With `REGDST_WB_RR_FAIR_EN`: grant order 0,1,2,3.
  - Without it, still re-asserting: requester 0 is granted every time.
- `stall`=1 for 3 cycles during WR1 → `reg_write`=0 and `grant`=0 for those cycles. The write completes with unchanged code and data in the first cycle after `stall` falls.
- Code 110 → `bad_code`=1, `reg_write`=0, `grant` still pulses. The next legal request writes normally.
- `reset` asserted in WR2 of a paired write → no `grant`, outputs at reset values. The held request is replayed from its first write.

Source files
------------

// File: rtl/regdst_wb_if.sv
// Write-back scheduler bus: requester side (master) and scheduler side (slave).
interface regdst_wb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             pair;
    logic [N_REQ-1:0][2:0]        dst_code;
    logic [N_REQ-1:0][2:0]        dst2_code;
    logic [N_REQ-1:0][DATA_W-1:0] wdata;
    logic [N_REQ-1:0][DATA_W-1:0] wdata2;
    logic                         stall;
    logic [N_REQ-1:0]             grant;
    logic [2:0]                   RegDst_control;
    logic                         reg_write;
    logic [DATA_W-1:0]            wb_data;
    logic                         busy;
    logic                         bad_code;

    modport master (
        output req, pair, dst_code, dst2_code, wdata, wdata2, stall,
        input  grant, RegDst_control, reg_write, wb_data, busy, bad_code
    );

    modport slave (
        input  req, pair, dst_code, dst2_code, wdata, wdata2, stall,
        output grant, RegDst_control, reg_write, wb_data, busy, bad_code
    );
endinterface

// File: rtl/regdst_wb_sched.sv
// Register-file write-back scheduler: arbitrates N_REQ requesters, drives the
// RegDst select code, write data and reg_write, and sequences paired writes.
// Optional: REGDST_WB_RR_FAIR_EN selects round-robin arbitration; otherwise
// fixed priority (lowest index wins).
module regdst_wb_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    regdst_wb_if.slave   wb
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       win_c, win_q;
    logic                win_vld;
    logic                pair_q;
    logic [2:0]          code_q, code2_q;
    logic [DATA_W-1:0]   data_q, data2_q;
    logic                busy_q;
    logic                active, legal, done, take;
    logic [N_REQ-1:0]    grant_c;
    logic                rw_c, bad_c;

    // A write is only acted on when not stalled and not being reset away.
    assign active = (state != IDLE) && !wb.stall && !reset;
    assign legal  = (code_q <= 3'b100);
    assign done   = active && ((state == WR2) || (state == WR1 && !pair_q));
    assign take   = (state == IDLE) && !wb.stall && win_vld;

`ifdef REGDST_WB_RR_FAIR_EN
    logic [IW-1:0] ptr_q;
    int            idx;

    // Round-robin pick: scan far-to-near so the nearest index at/after ptr wins.
    always_comb begin
        win_c   = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (wb.req[idx]) begin
                win_c   = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Pointer advances past the winner only on a real completion.
    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= '0;
        else if (done)
            ptr_q <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
    end
`else
    // Fixed priority pick: lowest requesting index wins.
    always_comb begin
        win_c   = '0;
        win_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (wb.req[k]) begin
                win_c   = IW'(k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and the unregistered write strobes.
    always_comb begin
        state_nxt = state;
        grant_c   = '0;
        rw_c      = 1'b0;
        bad_c     = 1'b0;
        case (state)
            IDLE:    if (take) state_nxt = WR1;
            WR1:     if (!wb.stall) state_nxt = pair_q ? WR2 : IDLE;
            WR2:     if (!wb.stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (done) grant_c = N_REQ'(1) << win_q;
        rw_c  = active && legal;
        bad_c = active && !legal;
    end

    // Latch the winner in IDLE; swap in the second write when WR1 moves to WR2.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q   <= '0;
            pair_q  <= 1'b0;
            code_q  <= '0;
            code2_q <= '0;
            data_q  <= '0;
            data2_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            if (take) begin
                win_q   <= win_c;
                pair_q  <= wb.pair[win_c];
                code_q  <= wb.dst_code[win_c];
                code2_q <= wb.dst2_code[win_c];
                data_q  <= wb.wdata[win_c];
                data2_q <= wb.wdata2[win_c];
            end else if (state == WR1 && !wb.stall && pair_q) begin
                code_q <= code2_q;
                data_q <= data2_q;
            end
        end
    end

    assign wb.grant          = grant_c;
    assign wb.reg_write      = rw_c;
    assign wb.bad_code       = bad_c;
    assign wb.RegDst_control = code_q;
    assign wb.wb_data        = data_q;
    assign wb.busy           = busy_q;
endmodule
